psum_omux: RTL

//  Output multiplexer downstream of the chain-head processing routers. Each channel takes one

---
 rtl/cnn_pkg.sv | 13 +
 rtl/psum_omux_fifo.sv | 47 ++++
 rtl/psum_omux.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared psum packet types used by the routers and the output mux
package cnn_pkg;

    localparam int PSUM_W      = 40;
    localparam int PSUM_ID_W   = 8;
    localparam int PSUM_DATA_W = 32;

    typedef struct packed {
        logic [PSUM_ID_W-1:0]   id;
        logic [PSUM_DATA_W-1:0] data;
    } psum_t;

endpackage

// File: rtl/psum_omux_fifo.sv
// rtl/psum_omux_fifo.sv - per-channel show-ahead psum FIFO with occupancy count
module psum_omux_fifo
    import cnn_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  psum_t            wr_data,
    input  logic             rd_en,
    output psum_t            head,
    output logic [CNT_W-1:0] count
);

    psum_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage needs no reset; count gates every use of its contents.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/psum_omux.sv
// rtl/psum_omux.sv - round-robin psum output mux; PSUM_OMUX_STATS_EN adds per-channel transfer counters
module psum_omux
    import cnn_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CH_W       = $clog2(N_CH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_CH-1:0]          ch_enable_i,
    input  logic [PSUM_W*N_CH-1:0]   psum_i,
    input  logic [N_CH-1:0]          psum_valid_i,
    output logic [N_CH-1:0]          stall_o,
`ifdef PSUM_OMUX_STATS_EN
    input  logic                     stats_clr_i,
    output logic [16*N_CH-1:0]       pkt_cnt_o,
`endif
    output logic [PSUM_W-1:0]        out_data_o,
    output logic [CH_W-1:0]          out_ch_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [N_CH-1:0]  wr;
    logic [N_CH-1:0]  rd;
    logic [N_CH-1:0]  nonempty;
    psum_t            head       [N_CH];
    logic [CNT_W-1:0] count      [N_CH];
    logic [CNT_W-1:0] count_next [N_CH];

    logic [CH_W-1:0]  rr;
    logic [CH_W-1:0]  grant;
    logic [CH_W-1:0]  cand;
    logic             grant_found;
    logic             load;

    for (genvar g = 0; g < N_CH; g++) begin : g_fifo
        psum_omux_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock   (clock),
            .reset   (reset),
            .wr_en   (wr[g]),
            .wr_data (psum_t'(psum_i[g*PSUM_W +: PSUM_W])),
            .rd_en   (rd[g]),
            .head    (head[g]),
            .count   (count[g])
        );
    end

    assign load = !out_valid_o || out_ready_i;

    // Search starts just after the last granted channel so every channel gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        cand        = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = CH_W'((int'(rr) + i) % N_CH);
            if (!grant_found && nonempty[cand]) begin
                grant_found = 1'b1;
                grant       = cand;
            end
        end
    end

    always_comb begin
        wr       = '0;
        rd       = '0;
        nonempty = '0;
        for (int k = 0; k < N_CH; k++) begin
            wr[k]         = psum_valid_i[k] && !stall_o[k];
            nonempty[k]   = (count[k] != '0);
            rd[k]         = load && grant_found && (grant == CH_W'(k));
            count_next[k] = count[k] + CNT_W'(wr[k]) - CNT_W'(rd[k]);
        end
    end

    // Stall from next-cycle occupancy lets the last slot fill and frees it on a same-cycle pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_o <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                stall_o[k] <= !ch_enable_i[k] || (count_next[k] == CNT_W'(FIFO_DEPTH));
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_ch_o    <= '0;
            rr          <= CH_W'(N_CH - 1);
        end else if (load) begin
            if (grant_found) begin
                out_valid_o <= 1'b1;
                out_data_o  <= head[grant];
                out_ch_o    <= grant;
                rr          <= grant;
            end else begin
                out_valid_o <= 1'b0;
            end
        end
    end

`ifdef PSUM_OMUX_STATS_EN
    logic [15:0] pkt_cnt [N_CH];

    always_ff @(posedge clock) begin
        if (reset || stats_clr_i) begin
            for (int k = 0; k < N_CH; k++) begin
                pkt_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (wr[k] && (pkt_cnt[k] != 16'hFFFF)) begin
                    pkt_cnt[k] <= pkt_cnt[k] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        pkt_cnt_o = '0;
        for (int k = 0; k < N_CH; k++) begin
            pkt_cnt_o[k*16 +: 16] = pkt_cnt[k];
        end
    end
`endif

endmodule
